// File: rtl/uart_rx_if.sv
// Receive-side handshake between uart_rx and its consumer: received byte, sticky
// ready flag, status flags and the ready/flag clear strobe.
interface uart_rx_if;
   logic [7:0] dout;
   logic       rdy;
   logic       parity_err;
   logic       frame_err;
   logic       overrun;
   logic       rdy_clr;

   modport master (output dout, rdy, parity_err, frame_err, overrun, input rdy_clr);
   modport slave  (input dout, rdy, parity_err, frame_err, overrun, output rdy_clr);
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits + parity + stop, oversampled by clk_en ticks.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote around every sample point.
module uart_rx #(
   parameter logic        PARITY_TYPE = 1'b0,
   parameter int unsigned OVERSAMPLE  = 16
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      clk_en,
   input  logic      rx,
   uart_rx_if.master bus
);
   localparam int unsigned   TW        = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] MID_START = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] MID_BIT   = TW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t        state;
   logic [1:0]    rx_sync;
   logic          rx_s;
   logic [TW-1:0] tick_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          perr;
   logic [7:0]    dout_r;
   logic          rdy_r;
   logic          pe_r;
   logic          fe_r;
   logic          ov_r;
   logic [TW-1:0] mid_cmp;
   logic          samp_now;
   logic          samp_val;
   logic          exp_par;
   logic          commit;
`ifdef UART_RX_MAJORITY_EN
   logic [1:0]    maj;
   logic          maj_pend;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rx_sync <= '1;
      else        rx_sync <= {rx_sync[0], rx};
   end
   assign rx_s = rx_sync[1];

   always_comb begin
      mid_cmp = (state == START) ? MID_START : MID_BIT;
      exp_par = PARITY_TYPE ? ~^shift : ^shift;
`ifdef UART_RX_MAJORITY_EN
      // Decision lands one tick after mid, once the third sample is on rx_s.
      samp_now = maj_pend;
      samp_val = (maj[0] & maj[1]) | (maj[0] & rx_s) | (maj[1] & rx_s);
`else
      samp_now = (tick_cnt == mid_cmp);
      samp_val = rx_s;
`endif
      commit = clk_en && (state == STOP) && samp_now;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         tick_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         perr     <= 1'b0;
         dout_r   <= '0;
         rdy_r    <= 1'b0;
         pe_r     <= 1'b0;
         fe_r     <= 1'b0;
         ov_r     <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
         maj      <= '0;
         maj_pend <= 1'b0;
`endif
      end else begin
         if (clk_en) begin
            case (state)
               IDLE: begin
                  tick_cnt <= '0;
                  if (!rx_s) state <= START;
               end
               START: begin
                  tick_cnt <= tick_cnt + 1'b1;
                  if (samp_now) begin
                     if (!samp_val) begin
                        state    <= DATA;
                        tick_cnt <= '0;
                        bit_idx  <= '0;
                     end else begin
                        state <= IDLE;
                     end
                  end
               end
               DATA: begin
                  tick_cnt <= tick_cnt + 1'b1;
                  if (samp_now) begin
                     shift[bit_idx] <= samp_val;
                     if (bit_idx == 3'd7) state   <= PARITY;
                     else                 bit_idx <= bit_idx + 3'd1;
                  end
               end
               PARITY: begin
                  tick_cnt <= tick_cnt + 1'b1;
                  if (samp_now) begin
                     perr  <= (samp_val != exp_par);
                     state <= STOP;
                  end
               end
               STOP: begin
                  tick_cnt <= tick_cnt + 1'b1;
                  if (samp_now) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
`ifdef UART_RX_MAJORITY_EN
            if (state == IDLE) begin
               maj_pend <= 1'b0;
            end else begin
               if (maj_pend) maj_pend <= 1'b0;
               if (tick_cnt == mid_cmp - 1'b1) maj[0] <= rx_s;
               if (tick_cnt == mid_cmp) begin
                  maj[1]   <= rx_s;
                  maj_pend <= 1'b1;
               end
            end
`endif
         end

         // Commit outranks a simultaneous rdy_clr; overrun then reads back as 0.
         if (commit) begin
            dout_r <= shift;
            rdy_r  <= 1'b1;
            pe_r   <= perr;
            fe_r   <= ~samp_val;
            ov_r   <= rdy_r & ~bus.rdy_clr;
         end else if (bus.rdy_clr) begin
            rdy_r <= 1'b0;
            pe_r  <= 1'b0;
            fe_r  <= 1'b0;
            ov_r  <= 1'b0;
         end
      end
   end

   assign bus.dout       = dout_r;
   assign bus.rdy        = rdy_r;
   assign bus.parity_err = pe_r;
   assign bus.frame_err  = fe_r;
   assign bus.overrun    = ov_r;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: even and odd parity instances share rx/clk_en/rdy_clr and are
// compared every clock against a frame-level model, plus directed literal checks.
module tb_uart_rx;
   localparam int OS          = 16;
   localparam int FRAME_TICKS = 11 * OS;
   // rx change is seen one tick later; start confirm OS/2 after that; stop mid is 10 bits on.
   localparam int COMMIT_TICK = 1 + OS / 2 + 10 * OS;

   logic clk     = 1'b0;
   logic rst_n   = 1'b0;
   logic clk_en  = 1'b0;
   logic rx      = 1'b1;
   logic rdy_clr = 1'b0;

   uart_rx_if bus_e ();
   uart_rx_if bus_o ();
   assign bus_e.rdy_clr = rdy_clr;
   assign bus_o.rdy_clr = rdy_clr;

   uart_rx #(.PARITY_TYPE(1'b0), .OVERSAMPLE(OS)) dut_e (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .rx(rx), .bus(bus_e.master));
   uart_rx #(.PARITY_TYPE(1'b1), .OVERSAMPLE(OS)) dut_o (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .rx(rx), .bus(bus_o.master));

   always #5 clk = ~clk;

   logic [7:0] m_dout;
   logic       m_rdy, m_pe0, m_pe1, m_fe, m_ov;
   int         errors = 0;
   int         checks = 0;
   bit         cmp_en = 1'b0;
   bit         c_pend = 1'b0;
   logic [7:0] c_byte;
   logic       c_pbit, c_stop;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_rdy = 1'b0; m_pe0 = 1'b0; m_pe1 = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
   endtask

   task automatic model_reset();
      model_clear();
      m_dout = 8'h00;
   endtask

   task automatic model_commit(input logic clr);
      m_ov   = m_rdy & ~clr;
      m_rdy  = 1'b1;
      m_dout = c_byte;
      m_pe0  = (c_pbit != (^c_byte));
      m_pe1  = (c_pbit != (~^c_byte));
      m_fe   = ~c_stop;
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         check("even_out", {bus_e.dout, bus_e.rdy, bus_e.parity_err, bus_e.frame_err, bus_e.overrun},
               {m_dout, m_rdy, m_pe0, m_fe, m_ov});
         check("odd_out", {bus_o.dout, bus_o.rdy, bus_o.parity_err, bus_o.frame_err, bus_o.overrun},
               {m_dout, m_rdy, m_pe1, m_fe, m_ov});
      end
   end

   // One oversample tick = two clocks; clk_en high on the first edge only.
   task automatic tick(input bit clr_a, input bit clr_b);
      clk_en  = 1'b1;
      rdy_clr = clr_a;
      @(posedge clk); #1;
      if (c_pend)     model_commit(clr_a);
      else if (clr_a) model_clear();
      clk_en  = 1'b0;
      rdy_clr = clr_b;
      @(posedge clk); #1;
      if (clr_b) model_clear();
      rdy_clr = 1'b0;
   endtask

   task automatic idle(input int n, input int clr_at);
      for (int t = 0; t < n; t++) begin
         rx = 1'b1;
         tick(t == clr_at, 1'b0);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic pbit, input logic stop,
                             input bit clr_commit, input int n_ticks, input bit rnd_clr);
      logic [10:0] bits;
      bit          ca, cb;
      bits = {stop, pbit, b, 1'b0};
      for (int t = 0; t < n_ticks; t++) begin
         rx     = bits[t / OS];
         c_pend = (t == COMMIT_TICK);
         c_byte = b; c_pbit = pbit; c_stop = stop;
         ca = c_pend ? clr_commit : (rnd_clr && $urandom_range(0, 63) == 0);
         cb = rnd_clr && $urandom_range(0, 63) == 0;
         tick(ca, cb);
      end
      c_pend = 1'b0;
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] b;
      logic       pbit, stop, prev_stop;
      int         gap;

      model_reset();
      cmp_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", {bus_e.dout, bus_e.rdy, bus_e.parity_err, bus_e.frame_err, bus_e.overrun}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      send_frame(8'hA5, 1'b0, 1'b1, 1'b0, FRAME_TICKS, 1'b0);
      check("a5_even", {bus_e.dout, bus_e.rdy, bus_e.parity_err, bus_e.frame_err, bus_e.overrun}, {8'hA5, 4'b1000});
      check("a5_odd_perr", bus_o.parity_err, 1);
      idle(8, 2);

      rx = 1'b0;
      repeat (4) tick(1'b0, 1'b0);
      idle(20, -1);
      check("glitch_rdy", bus_e.rdy, 0);
      send_frame(8'h3C, 1'b0, 1'b1, 1'b0, FRAME_TICKS, 1'b0);
      check("3c_after_glitch", {bus_e.dout, bus_e.rdy, bus_e.parity_err, bus_e.frame_err, bus_e.overrun}, {8'h3C, 4'b1000});
      idle(8, 2);

      send_frame(8'h01, 1'b0, 1'b1, 1'b0, FRAME_TICKS, 1'b0);
      check("01_even_perr", {bus_e.dout, bus_e.rdy, bus_e.parity_err, bus_e.frame_err, bus_e.overrun}, {8'h01, 4'b1100});
      check("01_odd_perr", bus_o.parity_err, 0);
      idle(8, 2);

      send_frame(8'h7E, 1'b0, 1'b0, 1'b0, FRAME_TICKS, 1'b0);
      check("7e_frame_err", {bus_e.dout, bus_e.rdy, bus_e.parity_err, bus_e.frame_err, bus_e.overrun}, {8'h7E, 4'b1010});
      idle(24, -1);
      tick(1'b0, 1'b1);
      check("clr_all", {bus_e.dout, bus_e.rdy, bus_e.parity_err, bus_e.frame_err, bus_e.overrun}, {8'h7E, 4'b0000});

      send_frame(8'h11, 1'b0, 1'b1, 1'b0, FRAME_TICKS, 1'b0);
      send_frame(8'h22, 1'b0, 1'b1, 1'b0, FRAME_TICKS, 1'b0);
      check("overrun", {bus_e.dout, bus_e.rdy, bus_e.parity_err, bus_e.frame_err, bus_e.overrun}, {8'h22, 4'b1001});
      idle(8, 2);
      send_frame(8'h11, 1'b0, 1'b1, 1'b0, FRAME_TICKS, 1'b0);
      send_frame(8'h22, 1'b0, 1'b1, 1'b1, FRAME_TICKS, 1'b0);
      check("overrun_clr_commit", {bus_e.dout, bus_e.rdy, bus_e.parity_err, bus_e.frame_err, bus_e.overrun}, {8'h22, 4'b1000});
      idle(8, 2);

      send_frame(8'hFF, 1'b0, 1'b1, 1'b0, 5 * OS, 1'b0);
      rst_n = 1'b0;
      model_reset();
      rx = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("midframe_reset", {bus_e.dout, bus_e.rdy, bus_e.parity_err, bus_e.frame_err, bus_e.overrun}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      idle(20, -1);
      check("no_partial_byte", bus_e.rdy, 0);
      send_frame(8'h5A, 1'b0, 1'b1, 1'b0, FRAME_TICKS, 1'b0);
      check("5a_after_reset", {bus_e.dout, bus_e.rdy, bus_e.parity_err, bus_e.frame_err, bus_e.overrun}, {8'h5A, 4'b1000});
      idle(8, 2);

      prev_stop = 1'b1;
      for (int n = 0; n < 40; n++) begin
         b    = 8'($urandom);
         pbit = (^b) ^ ($urandom_range(0, 4) == 0);
         stop = ($urandom_range(0, 5) != 0);
         if (prev_stop) gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 30));
         else           gap = 24 + int'($urandom_range(0, 8));
         idle(gap, ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 30)) : -1);
         send_frame(b, pbit, stop, $urandom_range(0, 3) == 0, FRAME_TICKS, 1'b1);
         prev_stop = stop;
      end
      idle(30, -1);

      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
